// File: rtl/forward_hazard_unit.sv
// rtl/forward_hazard_unit.sv - EX/ID operand forwarding, load-use stall FSM, branch flush and perf counters
module forward_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_ex_rs,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  id_ex_memread,
    input  logic                  id_ex_regwrite,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    input  logic [REG_ADDR_W-1:0] mem_wb_rd,
    input  logic                  ex_mem_regwrite,
    input  logic                  mem_wb_regwrite,
    input  logic                  branch_taken,
    input  logic                  perf_clr,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  fwd_id_a,
    output logic                  fwd_id_b,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int SL_W = $clog2(LOAD_LAT + 1);

    typedef enum logic {
        IDLE,
        STALL
    } state_t;

    state_t          state;
    logic [SL_W-1:0] stall_left;
    logic            ex_mem_hit_a, ex_mem_hit_b, mem_wb_hit_a, mem_wb_hit_b;
    logic            hazard;
    logic            stall;
    logic            flush;
    logic            unused_inputs;

    // The load-use check only needs memread; a load's regwrite adds nothing.
    assign unused_inputs = id_ex_regwrite;

    // Register 0 is hardwired, so a zero destination never matches anything.
    assign ex_mem_hit_a = ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == id_ex_rs);
    assign ex_mem_hit_b = ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == id_ex_rt);
    assign mem_wb_hit_a = mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == id_ex_rs);
    assign mem_wb_hit_b = mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == id_ex_rt);

    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        fwd_id_a  = 1'b0;
        fwd_id_b  = 1'b0;
        if (!rst) begin
            if (ex_mem_hit_a)      forward_a = 2'b01;
            else if (mem_wb_hit_a) forward_a = 2'b10;
            if (ex_mem_hit_b)      forward_b = 2'b01;
            else if (mem_wb_hit_b) forward_b = 2'b10;
            fwd_id_a = mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == id_rs);
            fwd_id_b = mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == id_rt);
        end
    end

    assign hazard = id_ex_memread && (id_ex_rd != '0) &&
                    ((id_ex_rd == id_rs) || (id_ex_rd == id_rt));

    // The first stall cycle comes straight from the hazard so there is no gap.
    assign stall = !rst && ((state == STALL) || hazard);
    assign flush = !rst && branch_taken && !stall;

    assign pc_write     = !stall;
    assign if_id_write  = !stall;
    assign id_ex_bubble = stall;
    assign if_id_flush  = flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            stall_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hazard && (LOAD_LAT > 1)) begin
                        state      <= STALL;
                        stall_left <= SL_W'(LOAD_LAT - 1);
                    end
                end
                STALL: begin
                    stall_left <= stall_left - 1'b1;
                    if (stall_left == SL_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    stall_left <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (flush && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 The block SHALL have parameter REG_ADDR_W, default 5, register-specifier width.
REQ-002 The block SHALL have parameter LOAD_LAT, default 1, data-memory read latency in cycles, legal range 1..8.
REQ-003 The block SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-004 Ports SHALL be, one per line:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_rs, id_rt  in  REG_ADDR_W  source specifiers of the instruction in ID
- id_ex_rs, id_ex_rt, id_ex_rd  in  REG_ADDR_W  specifiers in ID/EX
- id_ex_memread, id_ex_regwrite  in  1  ID/EX control
- ex_mem_rd, mem_wb_rd  in  REG_ADDR_W  destinations in EX/MEM and MEM/WB
- ex_mem_regwrite, mem_wb_regwrite  in  1  write enables
- branch_taken  in  1  branch resolved taken in ID
- perf_clr  in  1  clears both counters
- forward_a, forward_b  out  2  EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
- fwd_id_a, fwd_id_b  out  1  WB-to-ID bypass select for the ID operands
- pc_write, if_id_write  out  1  PC and IF/ID load enables
- id_ex_bubble  out  1  zero ID/EX control signals
- if_id_flush  out  1  squash IF/ID
- stall_cycles, flush_count  out  CNT_W  performance counters

Function
REQ-005 Register 0 SHALL never match: a zero destination SHALL NOT produce a forward, bypass or stall.
REQ-006 forward_a SHALL be 01 when ex_mem_regwrite is high and ex_mem_rd equals id_ex_rs. Otherwise it SHALL be 10 when mem_wb_regwrite is high and mem_wb_rd equals id_ex_rs. Otherwise it SHALL be 00. EX/MEM has priority.
REQ-007 forward_b SHALL follow REQ-006 with id_ex_rt in place of id_ex_rs.
REQ-008 fwd_id_a (fwd_id_b) SHALL be high when mem_wb_regwrite is high and mem_wb_rd equals id_rs (id_rt).
REQ-009 Forwarding and bypass outputs SHALL be combinational and SHALL be sensitive to every input they depend on.
REQ-010 A load-use hazard SHALL exist when all of the following hold: id_ex_memread is high, id_ex_rd is non-zero, and id_ex_rd equals id_rs or id_rt.
REQ-011 The FSM SHALL have two states, IDLE and STALL, plus a down-counter stall_left of width ceil(log2(LOAD_LAT+1)).
REQ-012 In IDLE with a hazard present, the stall SHALL be asserted in the same cycle. If LOAD_LAT is greater than 1, the FSM SHALL go to STALL with stall_left set to LOAD_LAT-1. If LOAD_LAT equals 1, the FSM SHALL stay in IDLE.
REQ-013 In STALL, the stall SHALL be asserted and stall_left SHALL decrement each cycle. When stall_left is 1, the FSM SHALL return to IDLE. The total stall SHALL be exactly LOAD_LAT cycles per hazard.
REQ-014 While stall is asserted: pc_write=0, if_id_write=0, id_ex_bubble=1. Otherwise: pc_write=1, if_id_write=1, id_ex_bubble=0.
REQ-015 if_id_flush SHALL equal branch_taken AND NOT stall. A branch coinciding with a stall SHALL be deferred. Its flush SHALL occur in the first non-stall cycle in which branch_taken is still high.
REQ-016 stall_cycles SHALL increment once per stall cycle.
REQ-017 flush_count SHALL increment once per cycle in which if_id_flush is high.
REQ-018 Both counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-019 perf_clr SHALL zero both counters on the next edge. It SHALL take priority over a simultaneous increment. It SHALL NOT affect the FSM.
REQ-020 A new hazard detected on the cycle the FSM returns to IDLE SHALL start a fresh stall with no gap cycle.

Reset
REQ-021 On a clk edge with rst high: state becomes IDLE, stall_left becomes 0, and stall_cycles and flush_count become 0.
REQ-022 While rst is high: forward_a=forward_b=00, fwd_id_a=fwd_id_b=0, pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0.
REQ-023 rst asserted during STALL SHALL abort the stall. The cycle after rst deasserts SHALL behave as IDLE.

Verification
REQ-024 The bench SHALL cover each of the following directed scenarios:
- Forwarding priority: ex_mem_rd=mem_wb_rd=id_ex_rs=5, both regwrite=1 -> forward_a=01. Set ex_mem_regwrite=0 -> forward_a=10. Set rd=0 -> forward_a=00.
- Load-use, LOAD_LAT=1: id_ex_memread=1, id_ex_rd=id_rt=7 -> exactly 1 cycle with pc_write=0 and id_ex_bubble=1, then stall_cycles=1.
- Load-use, LOAD_LAT=3: same stimulus -> stall for exactly 3 consecutive cycles, then IDLE, then stall_cycles=3. A rst pulse in cycle 2 -> stall ends immediately and counters read 0.
- Branch during stall: branch_taken=1 held through the hazard -> if_id_flush=0 during the stall, 1 in the next cycle, flush_count=1.
- Saturation: CNT_W=2 with 5 stall cycles -> stall_cycles=3. perf_clr together with an increment -> 0.
- WB bypass: mem_wb_regwrite=1, mem_wb_rd=id_rs=9 -> fwd_id_a=1 and fwd_id_b=0 (id_rt=2).
